textbuf_arb: RTL and testbench
==============================

TEXTBUF_ARB -- requirements
Module: textbuf_arb

Interface
- REQ-001 Parameter ADDRW, default 14: text buffer address width in bits.
- REQ-002 Parameter DATAW, default 32: text cell width in bits.
- REQ-003 Parameter MAX_WAIT, default 8: consecutive denied cycles after which port B is forced, range 1..255.
- REQ-004 clk_sys  input  1  system clock; the only clock.
- REQ-005 rst_sys  input  1  reset, synchronous, active-high.
- REQ-006 a_req  input  1  port A (display fetch, read-only) request.
- REQ-007 a_addr  input  ADDRW  port A read address.
- REQ-008 a_ack  output  1  port A request accepted this cycle.
- REQ-009 a_rvalid  output  1  port A read data valid.
- REQ-010 a_rdata  output  DATAW  port A read data.
- REQ-011 b_req  input  1  port B (system writer, read/write) request.
- REQ-012 b_we  input  1  port B write enable, qualified by b_req.
- REQ-013 b_addr  input  ADDRW  port B address.
- REQ-014 b_wdata  input  DATAW  port B write data.
- REQ-015 b_ack  output  1  port B request accepted this cycle.
- REQ-016 b_rvalid  output  1  port B read data valid.
- REQ-017 b_rdata  output  DATAW  port B read data.
- REQ-018 mem_addr  output  ADDRW  single-port RAM address.
- REQ-019 mem_we  output  1  single-port RAM write enable.
- REQ-020 mem_din  output  DATAW  single-port RAM write data.
- REQ-021 mem_dout  input  DATAW  RAM read data, valid one cycle after the address.

Function
- REQ-022 The block SHALL grant at most one port per cycle: a_ack and b_ack are never high together.
- REQ-023 a_ack and b_ack SHALL be combinational from the request inputs and the registered arbiter state.
- REQ-024 mem_addr, mem_we and mem_din SHALL be driven combinationally from the granted port in the same cycle.
- REQ-025 With no grant, mem_we SHALL be 0; mem_addr and mem_din are don't-care.
- REQ-026 mem_we SHALL equal b_we on a B grant and 0 on an A grant.
- REQ-027 Handshake: a requester holds req, addr, we and wdata stable until its ack; the transfer completes on the cycle req && ack.
- REQ-028 Read granted at cycle T: the matching rvalid SHALL be 1 at T+1 for exactly one cycle, with rdata = mem_dout at T+1.
- REQ-029 A B write SHALL produce no b_rvalid.
- REQ-030 a_rdata and b_rdata SHALL hold their last value when rvalid is 0.
- REQ-031 FSM state PRIO_A: A is granted whenever a_req=1; B is granted only when a_req=0.
- REQ-032 FSM state FORCE_B: B is granted if b_req=1, even when a_req=1.
- REQ-033 wait_cnt (8 bits) SHALL increment each cycle b_req=1 and b_ack=0.
- REQ-034 wait_cnt SHALL clear on any B grant or when b_req=0.
- REQ-035 Transition PRIO_A->FORCE_B SHALL occur at the clock edge where wait_cnt reaches MAX_WAIT, so B is granted on the following cycle.
- REQ-036 Transition FORCE_B->PRIO_A SHALL occur after exactly one B grant, or immediately if b_req drops to 0 (no grant).
- REQ-037 The block SHALL support back-to-back grants every cycle with no bubble, including an A->B switch and a B->A switch.
- REQ-038 Read data SHALL return in grant order; no reordering.
- REQ-039 A request dropped before its ack SHALL produce no memory access and no rvalid.

Reset
- REQ-040 While rst_sys=1: state=PRIO_A, wait_cnt=0, a_ack=b_ack=0, mem_we=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
- REQ-041 Reset asserted mid-operation SHALL discard any in-flight read: no rvalid on the cycle after reset releases.
- REQ-042 First grant SHALL be possible on the first cycle with rst_sys=0.

Verification
- REQ-043 A only, a_addr=0x0010 held 4 cycles -> 4 a_acks; a_rvalid on cycles 2..5 with data from 0x0010; b_ack=0 throughout.
- REQ-044 B write 0x0123 := 0xDEADBEEF, then B read 0x0123 -> mem_we=1 then 0; b_rvalid one cycle after the read ack with b_rdata=0xDEADBEEF.
- REQ-045 a_req and b_req both held high continuously, MAX_WAIT=8 -> pattern of 8 A grants then 1 B grant, repeating; never both acks high.
- REQ-046 a_req=1 continuously; b_req pulsed high 3 cycles then dropped -> no B grant, wait_cnt returns to 0, state stays PRIO_A.
- REQ-047 rst_sys asserted the cycle after an A read grant -> a_rvalid stays 0, all outputs at reset values, first grant on the first cycle after release.
- REQ-048 Alternating A and B reads every cycle, a_req and b_req never both high -> 100% memory utilisation; rdata order matches grant order.

Source files
------------

// File: rtl/textbuf_arb.sv
// Two-port arbiter in front of a single-port text RAM: display fetch (A) has priority, system writer (B) is forced after MAX_WAIT denials.
// Latency: grant is same-cycle combinational; read data and rvalid appear one cycle after the grant.
// Backpressure: a requester holds its request until ack; at most one port is acked per cycle.
module textbuf_arb #(
    parameter int ADDRW    = 14,
    parameter int DATAW    = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic             clk_sys,
    input  logic             rst_sys,

    input  logic             a_req,
    input  logic [ADDRW-1:0] a_addr,
    output logic             a_ack,
    output logic             a_rvalid,
    output logic [DATAW-1:0] a_rdata,

    input  logic             b_req,
    input  logic             b_we,
    input  logic [ADDRW-1:0] b_addr,
    input  logic [DATAW-1:0] b_wdata,
    output logic             b_ack,
    output logic             b_rvalid,
    output logic [DATAW-1:0] b_rdata,

    output logic [ADDRW-1:0] mem_addr,
    output logic             mem_we,
    output logic [DATAW-1:0] mem_din,
    input  logic [DATAW-1:0] mem_dout
);

    typedef enum logic {
        PRIO_A  = 1'b0,
        FORCE_B = 1'b1
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             a_pend_q, a_pend_d;
    logic             b_pend_q, b_pend_d;
    logic [DATAW-1:0] a_rdata_q, a_rdata_d;
    logic [DATAW-1:0] b_rdata_q, b_rdata_d;

    always_comb begin
        a_ack      = 1'b0;
        b_ack      = 1'b0;
        state_d    = state_q;
        wait_cnt_d = '0;

        if (!rst_sys) begin
            if (state_q == FORCE_B && b_req) begin
                b_ack = 1'b1;
            end else if (a_req) begin
                a_ack = 1'b1;
            end else if (b_req) begin
                b_ack = 1'b1;
            end
        end

        mem_we   = b_ack & b_we;
        mem_addr = b_ack ? b_addr : a_addr;
        mem_din  = b_wdata;

        if (b_req && !b_ack) begin
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
        end

        // FORCE_B lasts exactly one cycle: either B is granted or it has withdrawn.
        case (state_q)
            PRIO_A:  if (wait_cnt_d == MAX_WAIT_C) state_d = FORCE_B;
            FORCE_B: state_d = PRIO_A;
            default: state_d = PRIO_A;
        endcase

        a_pend_d = a_ack;
        b_pend_d = b_ack & ~b_we;

        a_rvalid  = a_pend_q & ~rst_sys;
        b_rvalid  = b_pend_q & ~rst_sys;
        a_rdata_d = a_rvalid ? mem_dout : a_rdata_q;
        b_rdata_d = b_rvalid ? mem_dout : b_rdata_q;
        a_rdata   = rst_sys ? '0 : a_rdata_d;
        b_rdata   = rst_sys ? '0 : b_rdata_d;
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state_q    <= PRIO_A;
            wait_cnt_q <= '0;
            a_pend_q   <= 1'b0;
            b_pend_q   <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            a_pend_q   <= a_pend_d;
            b_pend_q   <= b_pend_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

endmodule

// File: tb/tb_textbuf_arb.sv
// Randomized bench for textbuf_arb with a per-cycle reference model and a behavioural RAM.
module tb_textbuf_arb;
    localparam int ADDRW    = 14;
    localparam int DATAW    = 32;
    localparam int MAX_WAIT = 8;
    localparam int DEPTH    = 1 << ADDRW;

    logic             clk_sys = 1'b0;
    logic             rst_sys = 1'b1;
    logic             a_req = 1'b0;
    logic [ADDRW-1:0] a_addr = '0;
    logic             a_ack, a_rvalid;
    logic [DATAW-1:0] a_rdata;
    logic             b_req = 1'b0, b_we = 1'b0;
    logic [ADDRW-1:0] b_addr = '0;
    logic [DATAW-1:0] b_wdata = '0;
    logic             b_ack, b_rvalid;
    logic [DATAW-1:0] b_rdata;
    logic [ADDRW-1:0] mem_addr;
    logic             mem_we;
    logic [DATAW-1:0] mem_din;
    logic [DATAW-1:0] mem_dout = '0;

    textbuf_arb #(.ADDRW(ADDRW), .DATAW(DATAW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys),
        .a_req(a_req), .a_addr(a_addr), .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk_sys = ~clk_sys;

    // Single-port RAM, read-first, one cycle read latency.
    logic [DATAW-1:0] ram [0:DEPTH-1];
    always @(posedge clk_sys) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected memory contents, B denial count, pending read data.
    logic [DATAW-1:0] mdl_mem [0:DEPTH-1];
    int               denied = 0;
    bit               exp_a_pend = 0, exp_b_pend = 0;
    logic [DATAW-1:0] exp_a_pdata = '0, exp_b_pdata = '0, last_a = '0, last_b = '0;
    bit               g_a = 0, g_b = 0;

    always @(negedge clk_sys) begin
        bit               ea, eb;
        logic [DATAW-1:0] ead, ebd;
        if (rst_sys) begin
            chk("rst_a_ack", a_ack, 0);
            chk("rst_b_ack", b_ack, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_a_rvalid", a_rvalid, 0);
            chk("rst_b_rvalid", b_rvalid, 0);
            chk("rst_a_rdata", a_rdata, 0);
            chk("rst_b_rdata", b_rdata, 0);
            denied = 0;
            exp_a_pend = 0;
            exp_b_pend = 0;
            last_a = '0;
            last_b = '0;
            g_a = 0;
            g_b = 0;
        end else begin
            eb = b_req && (!a_req || denied >= MAX_WAIT);
            ea = a_req && !eb;
            chk("a_ack", a_ack, ea);
            chk("b_ack", b_ack, eb);
            chk("both_ack", a_ack & b_ack, 0);
            ead = exp_a_pend ? exp_a_pdata : last_a;
            ebd = exp_b_pend ? exp_b_pdata : last_b;
            chk("a_rvalid", a_rvalid, exp_a_pend);
            chk("b_rvalid", b_rvalid, exp_b_pend);
            chk("a_rdata", a_rdata, ead);
            chk("b_rdata", b_rdata, ebd);
            last_a = ead;
            last_b = ebd;
            chk("mem_we", mem_we, eb && b_we);
            if (ea) chk("mem_addr_a", mem_addr, a_addr);
            if (eb) chk("mem_addr_b", mem_addr, b_addr);
            if (eb && b_we) chk("mem_din", mem_din, b_wdata);
            exp_a_pend = ea;
            if (ea) exp_a_pdata = mdl_mem[a_addr];
            exp_b_pend = eb && !b_we;
            if (exp_b_pend) exp_b_pdata = mdl_mem[b_addr];
            if (eb && b_we) mdl_mem[b_addr] = b_wdata;
            denied = (b_req && !eb) ? denied + 1 : 0;
            g_a = ea;
            g_b = eb;
        end
    end

    // Raw DUT event counters for the hand-computed scenario checks.
    int n_a_ack = 0, n_b_ack = 0, n_a_rv = 0, n_b_rv = 0, n_we = 0;
    always @(negedge clk_sys) begin
        if (a_ack === 1'b1) n_a_ack++;
        if (b_ack === 1'b1) n_b_ack++;
        if (a_rvalid === 1'b1) n_a_rv++;
        if (b_rvalid === 1'b1) n_b_rv++;
        if (mem_we === 1'b1) n_we++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    initial begin
        int ba, bb, bra, brb, bw;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = 32'hC0DE0000 | 32'(i);
            mdl_mem[i] = 32'hC0DE0000 | 32'(i);
        end
        tick(3);
        rst_sys = 1'b0;

        // A only, same address held 4 cycles.
        ba = n_a_ack; bb = n_b_ack; bra = n_a_rv;
        a_req = 1'b1; a_addr = 14'h0010;
        tick(4);
        a_req = 1'b0;
        tick(1);
        chk("a_only_acks", n_a_ack - ba, 4);
        chk("a_only_rvalids", n_a_rv - bra, 4);
        chk("a_only_no_b", n_b_ack - bb, 0);
        chk("a_only_rdata", a_rdata, 32'hC0DE0010);

        // B write then B read of the same word.
        bb = n_b_ack; brb = n_b_rv; bw = n_we;
        b_req = 1'b1; b_we = 1'b1; b_addr = 14'h0123; b_wdata = 32'hDEADBEEF;
        tick(1);
        b_we = 1'b0;
        tick(1);
        b_req = 1'b0;
        tick(1);
        chk("b_wr_rd_acks", n_b_ack - bb, 2);
        chk("b_wr_rd_we", n_we - bw, 1);
        chk("b_wr_rd_rvalids", n_b_rv - brb, 1);
        chk("b_wr_rd_rdata", b_rdata, 32'hDEADBEEF);

        // Both requesting continuously: 8 A grants then 1 B grant, repeating.
        ba = n_a_ack; bb = n_b_ack;
        a_req = 1'b1; a_addr = 14'h0020;
        b_req = 1'b1; b_we = 1'b0; b_addr = 14'h0021;
        tick(8);
        chk("starve_b_first8", n_b_ack - bb, 0);
        tick(1);
        chk("starve_b_at9", n_b_ack - bb, 1);
        tick(18);
        chk("starve_b_27", n_b_ack - bb, 3);
        chk("starve_a_27", n_a_ack - ba, 24);
        a_req = 1'b0; b_req = 1'b0;
        tick(2);

        // Short B pulse under A traffic leaves no trace in the wait counter.
        bb = n_b_ack;
        a_req = 1'b1; a_addr = 14'h0030;
        b_req = 1'b1; b_addr = 14'h0031;
        tick(3);
        b_req = 1'b0;
        tick(2);
        chk("pulse_no_b", n_b_ack - bb, 0);
        b_req = 1'b1;
        tick(8);
        chk("pulse_cnt_cleared", n_b_ack - bb, 0);
        tick(1);
        chk("pulse_then_force", n_b_ack - bb, 1);
        a_req = 1'b0; b_req = 1'b0;
        tick(2);

        // Reset right after an A read grant.
        ba = n_a_ack; bra = n_a_rv;
        a_req = 1'b1; a_addr = 14'h0005;
        tick(1);
        rst_sys = 1'b1; a_req = 1'b0;
        #1;
        chk("midrst_a_rvalid", a_rvalid, 0);
        chk("midrst_a_rdata", a_rdata, 0);
        tick(1);
        rst_sys = 1'b0; a_req = 1'b1; a_addr = 14'h0006;
        #1;
        chk("midrst_first_grant", a_ack, 1);
        tick(1);
        a_req = 1'b0;
        tick(1);
        chk("midrst_acks", n_a_ack - ba, 2);
        chk("midrst_rvalids", n_a_rv - bra, 1);
        chk("midrst_rdata", a_rdata, 32'hC0DE0006);

        // Alternating A and B reads every cycle.
        ba = n_a_ack; bb = n_b_ack; bra = n_a_rv; brb = n_b_rv;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) begin
                a_req = 1'b1; b_req = 1'b0; a_addr = 14'(32'h40 + i);
            end else begin
                a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 14'(32'h40 + i);
            end
            tick(1);
        end
        a_req = 1'b0; b_req = 1'b0;
        tick(1);
        chk("alt_util", (n_a_ack - ba) + (n_b_ack - bb), 20);
        chk("alt_a_rv", n_a_rv - bra, 10);
        chk("alt_b_rv", n_b_rv - brb, 10);
        chk("alt_a_last", a_rdata, 32'hC0DE0052);
        chk("alt_b_last", b_rdata, 32'hC0DE0053);

        // Randomized traffic with occasional drops and resets.
        for (int c = 0; c < 4000; c++) begin
            if (rst_sys) rst_sys = 1'b0;
            if (a_req && g_a) a_req = 1'b0;
            if (b_req && g_b) b_req = 1'b0;
            if (a_req && $urandom_range(0, 31) == 0) a_req = 1'b0;
            if (b_req && $urandom_range(0, 31) == 0) b_req = 1'b0;
            if (!a_req && $urandom_range(0, 3) != 0) begin
                a_req  = 1'b1;
                a_addr = 14'($urandom_range(0, 15));
            end
            if (!b_req && $urandom_range(0, 2) == 0) begin
                b_req   = 1'b1;
                b_we    = $urandom_range(0, 1) == 1;
                b_addr  = 14'($urandom_range(0, 15));
                b_wdata = $urandom;
            end
            if ($urandom_range(0, 499) == 0) rst_sys = 1'b1;
            tick(1);
        end
        rst_sys = 1'b0; a_req = 1'b0; b_req = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
